bf16_add_arbiter: RTL and testbench
===================================

# bf16_add_arbiter

Round-robin arbiter that shares one pipelined bf16 adder datapath among N requesters. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants at most one requester per cycle and registers the winning operands into the adder. It carries the winner's ID through a tag pipeline matched to the adder latency, then returns the sum to the originating requester. It sits between the vector/accumulate front-ends and the shared bf16 adder instance.

## Interface
- N, default 4: number of requesters (2..8)
- LAT, default 2: adder latency, in cycles, from add_valid_o to a valid add_res_i (1..8)
- E, default 8: exponent width
- M, default 7: stored mantissa width; operand width W = 1+E+M = 16
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  N  per-requester operand-pair valid
- req_ready_o  out  N  per-requester grant (one-hot or zero)
- req_a_i  in  N*W  operand a, requester i at bits [i*W +: W], packed {s,e,m}
- req_b_i  in  N*W  operand b, same packing
- hold_i  in  1  when 1, no new grants are issued; in-flight work drains
- add_valid_o  out  1  operands valid to adder
- add_a_o  out  W  operand a to adder
- add_b_o  out  W  operand b to adder
- add_res_i  in  W  adder sum, valid exactly LAT cycles after the matching add_valid_o
- rsp_valid_o  out  N  one-hot response strobe to the originating requester
- rsp_res_o  out  W  sum, shared bus, qualified by rsp_valid_o
- busy_o  out  1  1 while any operation is in the tag pipeline or the response register

## Operation
- Round-robin pointer ptr (log2 N bits) holds the last granted ID. Search order is ptr+1, ptr+2, …, ptr (mod N). The first i with req_valid_i[i]=1 wins.
- req_ready_o[i] = winner==i && !hold_i. This is combinational from req_valid_i, ptr and hold_i. req_ready_o never depends on add_res_i.
- Transfer occurs when req_valid_i[i] && req_ready_o[i]. On a transfer:
  - ptr <= i.
  - add_a_o/add_b_o <= that requester's operands, and add_valid_o <= 1.
  - Tag pipeline stage 0 <= {1, i}.
- With no transfer, add_valid_o <= 0. add_a_o/add_b_o hold their last value.
- Tag pipeline: LAT stages of {valid, id}, shifting every cycle with no stall. The adder cannot backpressure.
- Response: when the last tag stage is valid, the arbiter registers rsp_res_o <= add_res_i and rsp_valid_o <= one-hot(id). Otherwise rsp_valid_o <= 0 and rsp_res_o holds.
- Requesters must accept responses; there is no response backpressure.
- Throughput is one operation per cycle sustained. No bubbles are inserted between back-to-back grants, including grants to the same requester.
- Fairness: a requester that keeps valid high is granted within N cycles unless hold_i is asserted.
- hold_i: it blocks new grants only. Tags already in flight still complete and respond. While hold_i=1, ptr does not change.
- The arbiter performs no arithmetic. Operands and sums pass through bit-exact.

## Timing
- Reset values:
  - ptr = N-1, so requester 0 has first priority.
  - All tag valid bits = 0.
  - add_valid_o = 0, add_a_o = 0, add_b_o = 0.
  - rsp_valid_o = 0, rsp_res_o = 0.
  - busy_o = 0.
- Handshake at edge t gives add_valid_o=1 during cycle t+1. add_res_i is sampled at edge t+1+LAT. rsp_valid_o is high during cycle t+LAT+2. Total latency is LAT+2 cycles.
- busy_o = add_valid_o | any tag valid | |rsp_valid_o. It rises the cycle after the first handshake and falls the cycle after the final response strobe.
- Reset asserted mid-operation clears everything immediately. In-flight results are dropped and no response is produced for them. Any add_res_i arriving after reset deasserts is ignored.
- Simultaneous events:
  - A new grant and a response to the same requester in the same cycle are independent and both happen.
  - If hold_i rises in the same cycle as a request, there is no grant that cycle.
- Pointer wrap: after granting N-1, the search starts at 0.

## Test plan
- Single request: N=4, LAT=2. Requester 2 sends a=0x3F80 (1.0) and b=0x4000 (2.0) at edge 0. Expect add_valid_o=1 with add_a_o=0x3F80 and add_b_o=0x4000 in cycle 1. The adder model returns 0x4040; expect rsp_valid_o=4'b0100 and rsp_res_o=0x4040 in cycle 4. busy_o is high in cycles 1–4.
- Full contention: all 4 requesters hold valid continuously after reset. Expect grants 0,1,2,3,0,1… on consecutive cycles and responses in the same order, each LAT+2 cycles after its grant.
- Sustained single requester: requester 1 alone sends 8 back-to-back pairs. Expect 8 consecutive grants, add_valid_o high for 8 cycles, and 8 consecutive rsp_valid_o=4'b0010 strobes with matching sums.
- Hold: with requests pending, assert hold_i for 3 cycles while 2 operations are in flight. Expect no grants, both responses delivered, and busy_o falling to 0. On release, the next grant goes to ptr+1.
- Reset mid-flight: grant requester 3, then assert rst 2 cycles later. Expect all outputs at reset values, no rsp_valid_o for the dropped operation, and requester 0 granted first after release.
- Wrap and skip: ptr=3, valid on requesters 1 and 3. Expect grant to 1, then 3, then 1.

Source files
------------

// File: rtl/bf16_add_arbiter.sv
// Round-robin arbiter sharing one pipelined bf16 adder among N requesters.
// The winner ID rides a tag pipeline matched to the adder latency and steers the sum back.
module bf16_add_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 2,
    parameter int E   = 8,
    parameter int M   = 7,
    localparam int W  = 1 + E + M,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid_i,
    output logic [N-1:0]   req_ready_o,
    input  logic [N*W-1:0] req_a_i,
    input  logic [N*W-1:0] req_b_i,
    input  logic           hold_i,
    output logic           add_valid_o,
    output logic [W-1:0]   add_a_o,
    output logic [W-1:0]   add_b_o,
    input  logic [W-1:0]   add_res_i,
    output logic [N-1:0]   rsp_valid_o,
    output logic [W-1:0]   rsp_res_o,
    output logic           busy_o
);

    logic [PW-1:0]           ptr_q;
    logic                    add_valid_q;
    logic [W-1:0]            add_a_q, add_b_q;
    logic [PW-1:0]           add_id_q;
    logic [LAT-1:0]          tag_vld_q;
    logic [LAT-1:0][PW-1:0]  tag_id_q;
    logic [N-1:0]            rsp_valid_q;
    logic [W-1:0]            rsp_res_q;

    logic                    win_vld;
    logic [PW-1:0]           win_id;
    logic                    xfer;
    logic [N-1:0]            gnt;
    int                      idx;

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            if (!win_vld && req_valid_i[idx]) begin
                win_vld = 1'b1;
                win_id  = PW'(idx);
            end
        end
    end

    assign xfer = win_vld && !hold_i;

    always_comb begin
        gnt = '0;
        if (xfer) gnt[win_id] = 1'b1;
    end

    assign req_ready_o = gnt;

    // Issue register (add_valid_q/add_id_q) followed by LAT tag stages lines the
    // last tag up with the cycle add_res_i is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= PW'(N - 1);
            add_valid_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_id_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
        end else begin
            add_valid_q <= xfer;
            if (xfer) begin
                ptr_q    <= win_id;
                add_id_q <= win_id;
                add_a_q  <= req_a_i[int'(win_id)*W +: W];
                add_b_q  <= req_b_i[int'(win_id)*W +: W];
            end
            tag_vld_q[0] <= add_valid_q;
            tag_id_q[0]  <= add_id_q;
            for (int j = 1; j < LAT; j++) begin
                tag_vld_q[j] <= tag_vld_q[j-1];
                tag_id_q[j]  <= tag_id_q[j-1];
            end
            if (tag_vld_q[LAT-1]) begin
                rsp_valid_q <= N'(1) << tag_id_q[LAT-1];
                rsp_res_q   <= add_res_i;
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign add_valid_o = add_valid_q;
    assign add_a_o     = add_a_q;
    assign add_b_o     = add_b_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_res_o   = rsp_res_q;
    assign busy_o      = add_valid_q | (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_bf16_add_arbiter.sv
// Randomized bench for bf16_add_arbiter: round-robin reference model, scoreboard of
// in-flight operations, and a behavioural bf16 adder with fixed latency.
module tb_bf16_add_arbiter;
    localparam int N   = 4;
    localparam int LAT = 2;
    localparam int W   = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid_i = '0;
    logic [N-1:0]   req_ready_o;
    logic [N*W-1:0] req_a_i = '0;
    logic [N*W-1:0] req_b_i = '0;
    logic           hold_i = 1'b0;
    logic           add_valid_o;
    logic [W-1:0]   add_a_o, add_b_o;
    logic [W-1:0]   add_res_i;
    logic [N-1:0]   rsp_valid_o;
    logic [W-1:0]   rsp_res_o;
    logic           busy_o;

    bf16_add_arbiter #(.N(N), .LAT(LAT), .E(8), .M(7)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .hold_i(hold_i),
        .add_valid_o(add_valid_o), .add_a_o(add_a_o), .add_b_o(add_b_o),
        .add_res_i(add_res_i),
        .rsp_valid_o(rsp_valid_o), .rsp_res_o(rsp_res_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // bf16 arithmetic via reals; truncating rounding is fine, the arbiter only forwards it.
    function automatic real bf2r(input logic [15:0] x);
        real r;
        int  e;
        if (x[14:7] == 8'd0) return 0.0;
        r = 1.0 + x[6:0] / 128.0;
        e = int'(x[14:7]) - 127;
        while (e > 0) begin r = r * 2.0; e--; end
        while (e < 0) begin r = r / 2.0; e++; end
        return x[15] ? -r : r;
    endfunction

    function automatic logic [15:0] r2bf(input real v);
        logic s;
        real  x;
        int   e, m;
        s = (v < 0.0);
        x = s ? -v : v;
        if (x == 0.0) return 16'h0000;
        e = 127;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0)  begin x = x * 2.0; e--; end
        if (e < 1) return {s, 15'h0};
        m = $rtoi((x - 1.0) * 128.0);
        return {s, e[7:0], m[6:0]};
    endfunction

    function automatic logic [15:0] bfadd(input logic [15:0] a, input logic [15:0] b);
        return r2bf(bf2r(a) + bf2r(b));
    endfunction

    // Adder: result appears exactly LAT cycles after add_valid_o, garbage otherwise.
    logic [W-1:0] apipe [LAT];
    always @(posedge clk) begin
        apipe[0] <= add_valid_o ? bfadd(add_a_o, add_b_o) : 16'hDEAD;
        for (int j = 1; j < LAT; j++) apipe[j] <= apipe[j-1];
    end
    assign add_res_i = apipe[LAT-1];

    typedef struct { int due; int id; logic [15:0] res; } op_t;

    op_t          sb[$];
    int           n_chk = 0, n_fail = 0, cyc = 0;
    int           m_ptr = N - 1;
    logic         e_av;
    logic [15:0]  e_a, e_b, e_rres;
    logic [15:0]  op_a [N];
    logic [15:0]  op_b [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [15:0] rnd_bf();
        logic [7:0] e;
        e = 8'(120 + $urandom_range(0, 14));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_a[i] = rnd_bf();
            op_b[i] = rnd_bf();
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_ptr  = N - 1;
        e_av   = 1'b0;
        e_a    = '0;
        e_b    = '0;
        e_rres = '0;
    endtask

    // One clock: drive inputs, check combinational grant, then registered outputs.
    task automatic step(input logic [N-1:0] v, input logic h);
        int w;
        logic [N-1:0] erdy, erv;
        op_t o;
        @(negedge clk);
        req_valid_i = v;
        hold_i      = h;
        for (int i = 0; i < N; i++) begin
            req_a_i[i*W +: W] = op_a[i];
            req_b_i[i*W +: W] = op_b[i];
        end
        #1;
        w = -1;
        for (int k = 1; k <= N; k++)
            if (w < 0 && v[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        erdy = (w >= 0 && !h) ? (N'(1) << w) : '0;
        chk("req_ready", 32'(req_ready_o), 32'(erdy));
        @(posedge clk);
        cyc++;
        if (erdy != 0) begin
            m_ptr = w;
            e_av  = 1'b1;
            e_a   = op_a[w];
            e_b   = op_b[w];
            o.due = cyc + LAT + 1;
            o.id  = w;
            o.res = bfadd(op_a[w], op_b[w]);
            sb.push_back(o);
        end else begin
            e_av = 1'b0;
        end
        #1;
        erv = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            erv    = N'(1) << sb[0].id;
            e_rres = sb[0].res;
            void'(sb.pop_front());
        end
        chk("add_valid", 32'(add_valid_o), 32'(e_av));
        chk("add_a", 32'(add_a_o), 32'(e_a));
        chk("add_b", 32'(add_b_o), 32'(e_b));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(erv));
        chk("rsp_res", 32'(rsp_res_o), 32'(e_rres));
        chk("busy", 32'(busy_o), 32'(sb.size() > 0 || erv != 0));
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 3; i++) step('0, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_add_valid", 32'(add_valid_o), 32'd0);
        chk("rst_add_ab", {add_a_o, add_b_o}, 32'd0);
        chk("rst_rsp", {12'd0, rsp_valid_o, rsp_res_o}, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_clear();
        rand_ops();
        apply_reset();

        // Single request: 1.0 + 2.0 from requester 2
        op_a[2] = 16'h3F80;
        op_b[2] = 16'h4000;
        step(4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) step('0, 1'b0);
        chk("single_sum", 32'(rsp_res_o), 32'h4040);
        apply_reset();

        // Full contention
        for (int i = 0; i < 12; i++) begin rand_ops(); step(4'b1111, 1'b0); end
        drain();

        // Sustained single requester
        for (int i = 0; i < 8; i++) begin rand_ops(); step(4'b0010, 1'b0); end
        drain();

        // Hold with two operations in flight, then release
        for (int i = 0; i < 2; i++) begin rand_ops(); step(4'b1111, 1'b0); end
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1);
        step(4'b1111, 1'b1);
        chk("hold_idle", 32'(busy_o), 32'd0);
        rand_ops();
        step(4'b1111, 1'b0);
        drain();

        // Reset mid-flight: grant requester 3, reset two cycles later
        apply_reset();
        rand_ops();
        step(4'b1000, 1'b0);
        step('0, 1'b0);
        apply_reset();
        for (int i = 0; i < LAT + 2; i++) step('0, 1'b0);
        rand_ops();
        step(4'b1111, 1'b0);
        chk("post_rst_first", 32'(add_a_o), 32'(op_a[0]));
        drain();

        // Wrap and skip from ptr = 3
        apply_reset();
        rand_ops();
        step(4'b1000, 1'b0);
        for (int i = 0; i < 3; i++) begin rand_ops(); step(4'b1010, 1'b0); end
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_ops();
            step(N'($urandom), ($urandom_range(0, 9) == 0));
        end
        drain();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1);
    end
endmodule
